l2_cfi_tcdm_responder: RTL and testbench

//  Responder (slave) end of the CFI-width TCDM bus driven by FC core/HWPE masters (req/gnt/r_valid).

---
 rtl/tcdm_cfi_pkg.sv | 9 +
 rtl/tcdm_resp_pipe.sv | 23 ++
 rtl/l2_cfi_tcdm_responder.sv | 59 +++++
 tb/tb_l2_cfi_tcdm_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tcdm_cfi_pkg.sv
// tcdm_cfi_pkg: shared response metadata type and word geometry for the CFI TCDM responder
package tcdm_cfi_pkg;
  localparam int WORD_BYTES = 4;
  typedef struct packed {
    logic valid;
    logic err;
    logic rd;
  } resp_meta_t;
endpackage

// File: rtl/tcdm_resp_pipe.sv
// tcdm_resp_pipe: reset-clearable fixed-depth shift register carrying response metadata
module tcdm_resp_pipe
  import tcdm_cfi_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = resp_meta_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  T     i_d,
  output T     o_q
);
  T r_sr [DEPTH];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/l2_cfi_tcdm_responder.sv
// l2_cfi_tcdm_responder: TCDM slave decoding requests onto one SRAM bank with fixed-latency in-order responses
module l2_cfi_tcdm_responder
  import tcdm_cfi_pkg::*;
#(
  parameter int          CFI_WIDTH   = 40,
  parameter int          BE_WIDTH    = CFI_WIDTH / 8,
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h1C000000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [CFI_WIDTH-1:0]  wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [CFI_WIDTH-1:0]  r_rdata_o,
  output logic                  r_opc_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [CFI_WIDTH-1:0]  mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic [CFI_WIDTH-1:0]  mem_rdata_i,
  input  logic                  mem_stall_i
);
  localparam int WB = $clog2(WORD_BYTES);
  if ((CFI_WIDTH % 8) != 0) begin : g_bad_width
    $error("CFI_WIDTH must be a multiple of 8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
    $error("MEM_LATENCY must be in 1..3");
  end
  logic [31:0] w_off;
  logic        w_hit;
  resp_meta_t  w_meta_d;
  resp_meta_t  w_meta_q;
  assign w_off       = add_i - BASE_ADDR;
  assign w_hit       = ((w_off >> (ADDR_WIDTH + WB)) == 32'd0) && (add_i[WB-1:0] == '0);
  assign gnt_o       = req_i & ~mem_stall_i;
  assign mem_req_o   = gnt_o & w_hit;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = w_off[ADDR_WIDTH+WB-1:WB];
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;
  assign w_meta_d    = '{valid: gnt_o, err: gnt_o & ~w_hit, rd: wen_i};
  tcdm_resp_pipe #(.DEPTH(MEM_LATENCY), .T(resp_meta_t)) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (w_meta_d),
    .o_q    (w_meta_q)
  );
  assign r_valid_o = w_meta_q.valid;
  assign r_opc_o   = w_meta_q.valid & w_meta_q.err;
  assign r_rdata_o = (w_meta_q.valid & w_meta_q.rd & ~w_meta_q.err) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_l2_cfi_tcdm_responder.sv
// tb_l2_cfi_tcdm_responder: random and directed stimulus checked against a transaction-level memory model
module tb_l2_cfi_tcdm_responder;
  localparam int          W    = 40;
  localparam int          BW   = W / 8;
  localparam int          AW   = 14;
  localparam int          LAT  = 3;
  localparam int          NW   = 1 << AW;
  localparam logic [31:0] BASE = 32'h1C000000;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [31:0]   add = '0;
  logic          wen = 1'b1;
  logic [W-1:0]  wdata = '0;
  logic [BW-1:0] be = '0;
  logic          stall = 1'b0;
  logic          gnt_o, r_valid_o, r_opc_o, mem_req_o, mem_we_o;
  logic [W-1:0]  r_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit last_granted = 1'b0;
  typedef struct {
    int           due;
    bit           err;
    logic [W-1:0] d;
  } exp_t;
  exp_t         q[$];
  logic [W-1:0] gold [NW];
  logic [W-1:0] sram [NW];
  logic [W-1:0] rd_pipe [LAT];
  l2_cfi_tcdm_responder #(
    .CFI_WIDTH(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MEM_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i), .mem_stall_i(stall)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic bit is_hit(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return off >= 0 && off < 4 * NW && a[1:0] == 2'b00;
  endfunction
  function automatic int word_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction
  initial begin
    for (int i = 0; i < NW; i++) begin
      gold[i] = '0;
      sram[i] = '0;
    end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
  end
  assign mem_rdata_i = rd_pipe[LAT-1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= '0;
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        rd_pipe[0] <= sram[mem_addr_o];
      end
    end
  end
  always @(negedge clk) begin
    bit   g, h;
    int   wi;
    exp_t e;
    g = req && !stall;
    h = is_hit(add);
    check("gnt", 64'(gnt_o), 64'(g));
    check("mem_req", 64'(mem_req_o), 64'(g && h));
    if (g && h) begin
      check("mem_we", 64'(mem_we_o), 64'(!wen));
      check("mem_addr", 64'(mem_addr_o), 64'(word_idx(add)));
      check("mem_wdata", 64'(mem_wdata_o), 64'(wdata));
      check("mem_be", 64'(mem_be_o), 64'(be));
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      check("r_valid", 64'(r_valid_o), 64'(1));
      check("r_opc", 64'(r_opc_o), 64'(q[0].err));
      check("r_rdata", 64'(r_rdata_o), 64'(q[0].d));
      void'(q.pop_front());
    end else begin
      check("r_valid_idle", 64'(r_valid_o), 64'(0));
      check("r_opc_idle", 64'(r_opc_o), 64'(0));
      check("r_rdata_idle", 64'(r_rdata_o), 64'(0));
    end
    if (g && rst_n) begin
      e.due = cyc + LAT;
      e.err = !h;
      e.d   = '0;
      if (h) begin
        wi = word_idx(add);
        if (wen) e.d = gold[wi];
        else for (int b = 0; b < BW; b++) if (be[b]) gold[wi][8*b +: 8] = wdata[8*b +: 8];
      end
      q.push_back(e);
    end
    if (!rst_n) q.delete();
  end
  task automatic cycle(input bit rq, input logic [31:0] a, input bit w,
                       input logic [W-1:0] d, input logic [BW-1:0] b, input bit st);
    req = rq; add = a; wen = w; wdata = d; be = b; stall = st;
    last_granted = rq && !st;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 1, '0, '0, 0);
  endtask
  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 4) return BASE + 32'(4 * $urandom_range(0, 31));
    if (k == 5) return BASE + 32'(4 * (NW - 1 - $urandom_range(0, 7)));
    if (k == 6) return BASE + 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
    if (k == 7) return BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 7));
    if (k == 8) return BASE - 32'(4 * $urandom_range(1, 8));
    return $urandom;
  endfunction
  initial begin
    logic [W-1:0] d;
    logic [31:0]  a;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    cycle(1, BASE + 32'h10, 0, 40'hA5_DEADBEEF, 5'h1F, 0);
    cycle(1, BASE + 32'h10, 1, '0, 5'h1F, 0);
    idle(LAT + 1);
    cycle(1, 32'h1C010000, 1, '0, 5'h1F, 0);
    cycle(1, BASE + 32'h2, 1, '0, 5'h1F, 0);
    cycle(1, 32'h1BFFFFFC, 1, '0, 5'h1F, 0);
    cycle(1, BASE + 32'h10, 0, 40'h11_22334455, 5'h00, 0);
    idle(LAT + 1);
    for (int i = 0; i < 8; i++) cycle(1, BASE + 32'(4 * (40 + i)), 0, {8'(i), 32'(i * 32'h01010101)}, 5'h1F, 0);
    for (int i = 0; i < 8; i++) cycle(1, BASE + 32'(4 * (40 + i)), 1, '0, 5'h1F, 0);
    idle(LAT + 1);
    cycle(1, BASE + 32'h20, 1, '0, 5'h1F, 0);
    for (int i = 0; i < 5; i++) cycle(1, BASE + 32'h24, 1, '0, 5'h1F, 1);
    cycle(1, BASE + 32'h24, 1, '0, 5'h1F, 0);
    idle(LAT + 1);
    cycle(1, BASE + 32'h10, 1, '0, 5'h1F, 0);
    cycle(1, BASE + 32'(4 * 41), 1, '0, 5'h1F, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(LAT + 3);
    for (int i = 0; i < 1500; i++) begin
      if (req && !last_granted) begin
        cycle(1, add, wen, wdata, be, $urandom_range(0, 3) == 0);
      end else begin
        a = rand_addr();
        d = {8'($urandom), 32'($urandom)};
        cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1, d,
              ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom), $urandom_range(0, 4) == 0);
      end
    end
    idle(LAT + 2);
    check("drain", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
